rom_reader: RTL

Read initiator for the synchronous `rom` block. On a `start` pulse it walks `length` consecutive ROM addresses from `base_addr`, wrapping modulo the ROM depth, and drives `rom_en`/`rom_addr`. It captures the registered `rom_out` data and presents it as a valid/ready stream. It sits between the ROM and any consumer that needs table contents streamed, and it absorbs consumer backpressure without losing or repeating words.

---
 rtl/rom_reader_pkg.sv | 22 ++
 rtl/rom_stream_buf.sv | 56 +++++
 rtl/rom_reader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rom_reader_pkg.sv
// Shared definitions for the rom_reader block.
//   - FSM state encodings (2 bits) and the enum built on them
//   - depth of the output stream buffer and the width of its entry count
package rom_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  localparam int unsigned BUF_DEPTH = 2;
  // Count must represent 0..BUF_DEPTH inclusive.
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/rom_stream_buf.sv
// Two-entry synchronous FIFO holding ROM words until the consumer takes them.
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   push, push_data  write one word at the tail
//   pop              remove the head word
//   head             current head word (valid when count != 0)
//   count            number of stored words, 0..BUF_DEPTH
// The caller guarantees no push when full and no pop when empty.
module rom_stream_buf
  import rom_reader_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] head,
  output logic [BUF_CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [data_width-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order. The two
  // storage entries are reset as well because the head word must read as zero
  // out of reset; for a deep memory that reset would be left off.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   count <= count + BUF_CNT_W'(1);
        2'b01:   count <= count - BUF_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/rom_reader.sv
// Read initiator for a synchronous ROM with one-cycle read latency.
// On start it reads `length` consecutive addresses from `base_addr`
// (wrapping modulo the ROM depth) and streams the words out as valid/ready,
// absorbing consumer backpressure in a 2-entry buffer.
// Ports:
//   clock, reset_n      rising-edge clock, synchronous active-low reset
//   start               request pulse, honoured only in IDLE
//   base_addr, length   transfer descriptor, sampled with start
//   busy, done          transfer in progress / one-cycle completion pulse
//   rom_en, rom_addr    ROM read request
//   rom_data            ROM registered output (valid the cycle after rom_en)
//   out_data, out_valid, out_ready   output stream
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [addr_width-1:0] rom_addr,
  input  logic [data_width-1:0] rom_data,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int IDX_W = addr_width + 1;
  localparam int OCC_W = BUF_CNT_W + 1;

  state_t                state;
  state_t                state_next;
  logic [addr_width-1:0] base_q;
  logic [addr_width-1:0] last_addr_q;
  logic [IDX_W-1:0]      len_q;
  logic [IDX_W-1:0]      index_q;
  logic                  inflight_q;
  logic [BUF_CNT_W-1:0]  count;
  logic [OCC_W-1:0]      occupancy;
  logic [addr_width-1:0] cur_addr;
  logic                  issue;
  logic                  pop;
  logic                  room;
  logic                  last_index;
  logic                  drained;

  assign pop = out_valid && out_ready;

  // Words that will be held after this edge if no new read is issued:
  // stored entries plus the word returning from last cycle's read, minus the
  // one the consumer takes now. Issuing only below the buffer depth means a
  // returning word always finds a free slot.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign room      = occupancy < OCC_W'(BUF_DEPTH);

  // Address arithmetic truncates to addr_width bits, giving the modulo wrap.
  assign cur_addr   = base_q + index_q[addr_width-1:0];
  assign last_index = index_q == (len_q - IDX_W'(1));

  // Finish as soon as the final word leaves: nothing returning from the ROM
  // and the buffer either empty or losing its last word this cycle.
  assign drained = !inflight_q && (count == BUF_CNT_W'(pop));

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (length == '0) ? DONE : READ;
      end
      READ: begin
        issue = room;
        if (room && last_index) state_next = DRAIN;
      end
      DRAIN: begin
        if (drained) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      base_q      <= '0;
      len_q       <= '0;
      index_q     <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      // A ROM word comes back exactly one cycle after each issued read.
      inflight_q <= issue;
      if (state == IDLE && start) begin
        base_q  <= base_addr;
        len_q   <= length;
        index_q <= '0;
      end else if (issue) begin
        index_q     <= index_q + IDX_W'(1);
        last_addr_q <= cur_addr;
      end
    end
  end

  assign rom_en   = issue;
  // Show the address being read; otherwise keep the last one issued.
  assign rom_addr = issue ? cur_addr : last_addr_q;
  assign busy     = (state == READ) || (state == DRAIN);
  assign done     = (state == DONE);

  rom_stream_buf #(
    .data_width (data_width)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (rom_data),
    .pop       (pop),
    .head      (out_data),
    .count     (count)
  );

  assign out_valid = (count != '0);

endmodule
